// File: rtl/chunked_serial_adder.sv
// -----------------------------------------------------------------------------
// chunked_serial_adder
//
// Multi-cycle adder/subtractor. Two WIDTH-bit operands are combined CHUNK bits
// per clock, least-significant chunk first. Each chunk is a CHUNK-bit ripple of
// full adders; a carry register links one chunk to the next, so a WIDTH-bit
// add costs NCHUNK = WIDTH/CHUNK cycles of a CHUNK-bit adder.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. The producer keeps its data stable while
// valid is high and ready is low; the consumer may raise or drop ready freely.
// in_ready and out_valid are registered and never depend combinationally on
// in_valid or out_ready.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      block can accept operands (IDLE only)
//   a, b       in   WIDTH  operands
//   cin        in   1      carry-in (add) / borrow-in (sub)
//   sub        in   1      0: a+b+cin, 1: a-b-cin
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result modulo 2^WIDTH (meaningful while out_valid)
//   cout       out  1      raw carry out of the MSB (sub: 1 = no borrow)
//   ovf        out  1      two's-complement signed overflow
//   busy       out  1      high in RUN and DONE
//   dbg_state  out  2      current FSM state (IDLE=0, RUN=1, DONE=2)
// -----------------------------------------------------------------------------
module chunked_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Reject parameter sets that would leave a partial chunk at the top.
  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("chunked_serial_adder: WIDTH must be a positive multiple of CHUNK");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q,     state_d;
  logic [WIDTH-1:0] a_q,         a_d;
  logic [WIDTH-1:0] b_q,         b_d;      // b already inverted for subtract
  logic             carry_q,     carry_d;
  logic [IDXW-1:0]  idx_q,       idx_d;
  logic [WIDTH-1:0] sum_q,       sum_d;
  logic             cout_q,      cout_d;
  logic             ovf_q,       ovf_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q,      busy_d;

  // ---------------------------------------------------------------------------
  // Chunk datapath: one CHUNK-bit ripple adder shared by every chunk.
  // rip[i] is the carry into bit i of the current chunk, so for the top chunk
  // rip[CHUNK-1] is the carry into the operand MSB and rip[CHUNK] the carry out.
  // ---------------------------------------------------------------------------
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic [CHUNK:0]   rip;

  always_comb begin
    a_chunk = a_q[int'(idx_q)*CHUNK +: CHUNK];
    b_chunk = b_q[int'(idx_q)*CHUNK +: CHUNK];
    s_chunk = '0;
    rip     = '0;
    rip[0]  = carry_q;
    for (int i = 0; i < CHUNK; i++) begin
      s_chunk[i] = a_chunk[i] ^ b_chunk[i] ^ rip[i];
      rip[i+1]   = (a_chunk[i] & b_chunk[i]) | (rip[i] & (a_chunk[i] ^ b_chunk[i]));
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and register next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    case (state_q)
      S_IDLE: begin
        // in_ready comes up one edge after reset release and stays up in IDLE.
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          a_d        = a;
          // Subtraction as a + ~b + ~borrow: inverting b and the borrow-in
          // turns a-b-cin into a plain add with the same ripple hardware.
          b_d        = sub ? ~b : b;
          carry_d    = sub ^ cin;
          idx_d      = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        sum_d[int'(idx_q)*CHUNK +: CHUNK] = s_chunk;
        carry_d = rip[CHUNK];
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          cout_d      = rip[CHUNK];
          ovf_d       = rip[CHUNK] ^ rip[CHUNK-1];
          idx_d       = '0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        // Result registers are untouched here, so they hold while stalled.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule
